// File: rtl/serial_sub_n.sv
// serial_sub_n: bit-serial N-bit subtractor computing a - b - bin, LSB first,
// one bit per clock, with a start/busy/done handshake.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output 'ovf' (borrow into the MSB XOR borrow-out).
module serial_sub_n #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         busy,
`ifdef SERIAL_SUB_OVF_EN
    output logic         done,
    output logic         ovf
`else
    output logic         done
`endif
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_sa;
    logic [N-1:0]   r_sb;
    logic [N-1:0]   r_sd;
    logic           r_br;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_diff;
    logic           r_bout;
    logic           r_busy;
    logic           r_done;
`ifdef SERIAL_SUB_OVF_EN
    logic           r_ovf;
`endif

    logic           w_d;
    logic           w_brNext;
    logic [N-1:0]   w_sdNext;
    logic           w_last;

    // One-bit full-subtractor slice on the current LSBs plus the next result shift value
    always_comb begin
        w_d      = r_sa[0] ^ r_sb[0] ^ r_br;
        w_brNext = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
        w_sdNext = {w_d, r_sd[N-1:1]};
        w_last   = (r_cnt == CW'(N - 1));
    end

    // Control FSM and datapath: capture operands in IDLE, shift one bit per clock in SHIFT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sd    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_sd  <= w_sdNext;
                    r_br  <= w_brNext;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff  <= w_sdNext;
                        r_bout  <= w_brNext;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf   <= r_br ^ w_brNext;
`endif
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign busy = r_busy;
    assign done = r_done;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub_n.sv
// tb_serial_sub_n: self-checking bench for serial_sub_n (N=4).
// An arithmetic reference model predicts busy/done/diff/bout (and ovf when
// SERIAL_SUB_OVF_EN is defined) every cycle; directed cases pin literals.
module tb_serial_sub_n;

    localparam int N   = 4;
    localparam int MOD = 1 << N;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a     = '0;
    logic [N-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic [N-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_sub_n #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
`ifdef SERIAL_SUB_OVF_EN
        .done  (done),
        .ovf   (ovf)
`else
        .done  (done)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Arithmetic reference functions
    function automatic logic [N-1:0] refDiff(input int x, input int y, input int c);
        return N'((x - y - c + 2 * MOD) % MOD);
    endfunction

    function automatic logic refBout(input int x, input int y, input int c);
        return (x < y + c);
    endfunction

    function automatic logic refOvf(input int x, input int y, input int c);
        int sx;
        int sy;
        int r;
        sx = (x >= MOD / 2) ? x - MOD : x;
        sy = (y >= MOD / 2) ? y - MOD : y;
        r  = sx - sy - c;
        return (r < -(MOD / 2)) || (r > MOD / 2 - 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: remaining busy edges, pending and presented results
    int           mLeft = 0;
    logic [N-1:0] mDiff = '0;
    logic [N-1:0] pDiff = '0;
    logic         mBout = 1'b0;
    logic         pBout = 1'b0;
    logic         mOvf  = 1'b0;
    logic         pOvf  = 1'b0;
    logic         mDone = 1'b0;

    // Transaction-level model: an accepted start produces its result N edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mLeft <= 0;
            mDiff <= '0;
            mBout <= 1'b0;
            mOvf  <= 1'b0;
            mDone <= 1'b0;
        end else begin
            mDone <= 1'b0;
            if (mLeft > 0) begin
                mLeft <= mLeft - 1;
                if (mLeft == 1) begin
                    mDone <= 1'b1;
                    mDiff <= pDiff;
                    mBout <= pBout;
                    mOvf  <= pOvf;
                end
            end else if (start) begin
                mLeft <= N;
                pDiff <= refDiff(int'(a), int'(b), int'(bin));
                pBout <= refBout(int'(a), int'(b), int'(bin));
                pOvf  <= refOvf(int'(a), int'(b), int'(bin));
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model, away from the active edge
    always @(negedge clk) begin
        check("busy", int'(busy), int'(mLeft > 0));
        check("done", int'(done), int'(mDone));
        check("diff", int'(diff), int'(mDiff));
        check("bout", int'(bout), int'(mBout));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", int'(ovf), int'(mOvf));
`endif
    end

    // Wait (bounded) for done; cyc returns negedges elapsed
    task automatic waitDone(input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < N + 4);
        if (!done) begin
            errors++;
            checks++;
            $display("[TB] FAIL %s_timeout: got done=0 expected done=1 within %0d cycles", name, N + 4);
        end
    endtask

    // Launch one operation and run it to completion; inputs scrambled after acceptance
    task automatic applyStimulus(input string name, input int ta, input int tb, input int tbin, output int cyc);
        @(negedge clk);
        a     = N'(ta);
        b     = N'(tb);
        bin   = tbin[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        bin   = 1'($urandom);
        waitDone(name, cyc);
    endtask

    // Hand-computed literal checks against both the DUT and the model
    task automatic checkOutput(input string name, input int expDiff, input int expBout);
        check({name, "_diff"}, int'(diff), expDiff);
        check({name, "_bout"}, int'(bout), expBout);
        check({name, "_mdl_diff"}, int'(mDiff), expDiff);
        check({name, "_mdl_bout"}, int'(mBout), expBout);
    endtask

    // Directed sequence, reset abort, and exhaustive sweep
    initial begin
        int cyc;
        int idx;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 0, 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst_n = 1'b1;

        // Basic: 7-5 with latency check
        @(negedge clk);
        a = 4'd7; b = 4'd5; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("basic_busy_edge0", int'(busy), 1);
        waitDone("basic", cyc);
        check("basic_latency", cyc, N);
        checkOutput("basic", 2, 0);
        @(negedge clk);
        check("basic_done_pulse", int'(done), 0);
        check("basic_hold_diff", int'(diff), 2);

        // Borrow cases
        applyStimulus("b1", 3, 7, 0, cyc); checkOutput("b1", 12, 1);
        applyStimulus("b2", 5, 6, 1, cyc); checkOutput("b2", 14, 1);
        applyStimulus("b3", 0, 0, 1, cyc); checkOutput("b3", 15, 1);
        applyStimulus("b4", 8, 8, 0, cyc); checkOutput("b4", 0, 0);

        // Start pulsed mid-operation is ignored
        @(negedge clk);
        a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("ignore", cyc);
        checkOutput("ignore", 5, 0);

        // Back-to-back: start held in the done cycle
        a = 4'd6; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", int'(busy), 1);
        waitDone("b2b", cyc);
        check("b2b_spacing", cyc + 1, N + 1);
        checkOutput("b2b", 4, 0);

        // Reset mid-operation
        @(negedge clk);
        a = 4'd13; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort", 0, 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("after_reset", 13, 2, 0, cyc);
        checkOutput("after_reset", 11, 0);

`ifdef SERIAL_SUB_OVF_EN
        applyStimulus("o1", 8, 1, 0, cyc); checkOutput("o1", 7, 0);  check("o1_ovf", int'(ovf), 1);
        applyStimulus("o2", 7, 8, 0, cyc); checkOutput("o2", 15, 1); check("o2_ovf", int'(ovf), 1);
        applyStimulus("o3", 6, 9, 0, cyc); checkOutput("o3", 13, 1); check("o3_ovf", int'(ovf), 1);
        applyStimulus("o4", 4, 4, 1, cyc); checkOutput("o4", 15, 1); check("o4_ovf", int'(ovf), 0);
`endif

        // Sweep of all (a, b, bin) in a scrambled order; model checks every cycle
        for (int i = 0; i < 2 * MOD * MOD; i++) begin
            idx = (i * 167) % (2 * MOD * MOD);
            applyStimulus("sweep", idx % MOD, (idx / MOD) % MOD, idx / (MOD * MOD), cyc);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
